flit_group_pipeline: RTL and testbench



---
 rtl/flit_group_pipeline_pkg.sv | 27 ++
 rtl/flit_group_pipeline_group_fifo.sv | 63 ++++++
 rtl/flit_group_pipeline.sv | 135 +++++++++++++
 tb/tb_flit_group_pipeline.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_group_pipeline_pkg.sv
// Shared types and helpers for the flit group pipeline.
// Default geometry, lane mask, assembly states, header-bit placement.
package flit_group_pipeline_pkg;

  localparam int NPORTS_DEF = 4;
  localparam int FLIT_W_DEF = 7;
  localparam int OUT_W_DEF  = 11;
  localparam int DEPTH_DEF  = 5;

  typedef logic [NPORTS_DEF-1:0] lane_mask_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asm_state_t;

  // Output bit index for input flit bit i: the header (MSB)
  // moves to the top of the wider lane, the rest stay put.
  function automatic int hdr_pos(
    input int bit_i,
    input int flit_w,
    input int out_w
  );
    return (bit_i == flit_w - 1) ? out_w - 1 : bit_i;
  endfunction

endpackage

// File: rtl/flit_group_pipeline_group_fifo.sv
// Group FIFO: DEPTH entries of W bits, head read from storage.
// Ports: clk, rst, push/push_data, pop/head, count, full, empty.
module flit_group_pipeline_group_fifo #(
  parameter int DEPTH = 5,
  parameter int W     = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CAP);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves
  // on the same edge; the freed slot is the one written.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/flit_group_pipeline.sv
// Flit group pipeline: assembles one flit per lane into groups, queues them.
// Ports: clk, rst, start, in_valid/in_flit/flush/in_ready, out_*, count, dup_err.
module flit_group_pipeline
  import flit_group_pipeline_pkg::*;
#(
  parameter int NPORTS = NPORTS_DEF,
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*FLIT_W-1:0] in_flit,
  input  logic                     flush,
  output logic                     in_ready,
  output logic [NPORTS-1:0]        out_valid,
  output logic [NPORTS*OUT_W-1:0]  out_flit,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         count,
  output logic                     dup_err
);

  localparam int SW = FLIT_W + 1;

  asm_state_t state;
  asm_state_t state_nx;

  logic [NPORTS-1:0]             filled;
  logic [NPORTS-1:0]             filled_nx;
  logic [NPORTS-1:0]             cap;
  logic [NPORTS-1:0][FLIT_W-1:0] slot;
  logic                          complete;
  logic                          started;
  logic                          show;
  logic                          push;
  logic                          pop;
  logic                          full;
  logic                          empty;
  logic [NPORTS*SW-1:0]          grp;
  logic [NPORTS*SW-1:0]          head;
  logic [NPORTS-1:0][OUT_W-1:0]  lane_out;

  assign in_ready = (state == FILL);
  assign show     = started & ~empty;
  assign pop      = show & out_ready;
  assign push     = (state == HOLD) & (~full | pop);

  always_comb begin
    state_nx  = state;
    filled_nx = filled;
    cap       = '0;
    complete  = 1'b0;
    unique case (state)
      FILL: begin
        cap       = in_valid & ~filled;
        filled_nx = filled | cap;
        // Flush only closes a group that holds something,
        // including lanes captured on this very edge.
        complete  = (&filled_nx) | (flush & (|filled_nx));
        if (complete) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (push) begin
          state_nx  = FILL;
          filled_nx = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      filled  <= '0;
      slot    <= '0;
      started <= 1'b0;
      dup_err <= 1'b0;
    end else begin
      state  <= state_nx;
      filled <= filled_nx;
      for (int p = 0; p < NPORTS; p++) begin
        if (cap[p]) begin
          slot[p] <= in_flit[p*FLIT_W +: FLIT_W];
        end
      end
      if (start) begin
        started <= 1'b1;
      end
      if (in_ready && |(in_valid & filled)) begin
        dup_err <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_grp
    assign grp[p*SW +: SW] = {filled[p], slot[p]};
  end

  flit_group_pipeline_group_fifo #(
    .DEPTH (DEPTH),
    .W     (NPORTS * SW),
    .CNT_W (CNT_W)
  ) group_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (grp),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  for (genvar p = 0; p < NPORTS; p++) begin : g_lane
    logic on;
    assign on           = show & head[p*SW + FLIT_W];
    assign out_valid[p] = on;
    for (genvar i = 0; i < FLIT_W; i++) begin : g_bit
      localparam int OP = hdr_pos(i, FLIT_W, OUT_W);
      assign lane_out[p][OP] = on & head[p*SW + i];
    end
    if (OUT_W > FLIT_W) begin : g_pad
      assign lane_out[p][OUT_W-2:FLIT_W-1] = '0;
    end
  end

  assign out_flit = lane_out;

endmodule

// File: tb/tb_flit_group_pipeline.sv
// Bench for flit_group_pipeline: vector table, corner sequences, random run.
// Compares every cycle against a queue-based group model.
module tb_flit_group_pipeline;
  import flit_group_pipeline_pkg::*;

  localparam int NP = 4;
  localparam int FW = 7;
  localparam int OW = 11;
  localparam int D  = 5;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             flush;
  logic             out_ready;
  logic             in_ready;
  logic             dup_err;
  lane_mask_t       in_valid;
  lane_mask_t       out_valid;
  logic [NP*FW-1:0] in_flit;
  logic [NP*OW-1:0] out_flit;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  flit_group_pipeline #(
    .NPORTS (NP),
    .FLIT_W (FW),
    .OUT_W  (OW),
    .DEPTH  (D),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_ready (out_ready),
    .count     (count),
    .dup_err   (dup_err)
  );

  typedef struct packed {
    logic [NP-1:0]    m;
    logic [NP*FW-1:0] f;
  } grp_t;

  grp_t             q[$];
  lane_mask_t       m_mask;
  logic [NP*FW-1:0] m_slot;
  logic             m_hold;
  logic             m_started;
  logic             m_dup;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [OW-1:0] mapf(input logic [FW-1:0] f);
    return (OW'(f[FW-1]) << (OW - 1)) | OW'(f[FW-2:0]);
  endfunction

  function automatic logic [NP*FW-1:0] lf(input int p, input logic [FW-1:0] v);
    return (NP*FW)'(v) << (p * FW);
  endfunction

  function automatic logic [NP*OW-1:0] lo(input int p, input logic [OW-1:0] v);
    return (NP*OW)'(v) << (p * OW);
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mask    = '0;
    m_slot    = '0;
    m_hold    = 1'b0;
    m_started = 1'b0;
    m_dup     = 1'b0;
    q.delete();
  endfunction

  function automatic void model_update(
    input logic r, input logic st, input logic fl, input logic orr,
    input lane_mask_t v, input logic [NP*FW-1:0] f
  );
    logic pop_now;
    logic push_now;
    grp_t g;
    if (r) begin
      model_reset();
      return;
    end
    pop_now  = m_started && q.size() > 0 && orr;
    push_now = m_hold && (q.size() < D || pop_now);
    if (pop_now) void'(q.pop_front());
    if (push_now) begin
      g.m = m_mask;
      g.f = m_slot;
      q.push_back(g);
      m_mask = '0;
      m_hold = 1'b0;
    end else if (!m_hold) begin
      for (int p = 0; p < NP; p++) begin
        if (v[p]) begin
          if (m_mask[p]) m_dup = 1'b1;
          else begin
            m_mask[p] = 1'b1;
            m_slot[p*FW +: FW] = f[p*FW +: FW];
          end
        end
      end
      if (&m_mask || (fl && |m_mask)) m_hold = 1'b1;
    end
    if (st) m_started = 1'b1;
  endfunction

  task automatic check_model();
    lane_mask_t       ev;
    logic [NP*OW-1:0] eo;
    ev = '0;
    eo = '0;
    if (m_started && q.size() > 0) begin
      ev = q[0].m;
      for (int p = 0; p < NP; p++)
        if (ev[p]) eo[p*OW +: OW] = mapf(q[0].f[p*FW +: FW]);
    end
    cmp("in_ready", 64'(in_ready), 64'(!m_hold));
    cmp("out_valid", 64'(out_valid), 64'(ev));
    cmp("out_flit", 64'(out_flit), 64'(eo));
    cmp("count", 64'(count), 64'(q.size()));
    cmp("dup_err", 64'(dup_err), 64'(m_dup));
  endtask

  task automatic step(
    input logic r, input logic st, input logic fl, input logic orr,
    input lane_mask_t v, input logic [NP*FW-1:0] f
  );
    rst       = r;
    start     = st;
    flush     = fl;
    out_ready = orr;
    in_valid  = v;
    in_flit   = f;
    @(negedge clk);
    check_model();
    model_update(r, st, fl, orr, v, f);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             st;
    logic             fl;
    logic             orr;
    lane_mask_t       v;
    logic [NP*FW-1:0] f;
    logic             e_rdy;
    lane_mask_t       e_ov;
    logic [NP*OW-1:0] e_of;
    logic [CW-1:0]    e_cnt;
    logic             e_dup;
  } vec_t;

  function automatic vec_t row(
    input logic st, input logic fl, input logic orr,
    input lane_mask_t v, input logic [NP*FW-1:0] f,
    input logic e_rdy, input lane_mask_t e_ov,
    input logic [NP*OW-1:0] e_of, input logic [CW-1:0] e_cnt,
    input logic e_dup
  );
    vec_t x;
    x.st = st; x.fl = fl; x.orr = orr; x.v = v; x.f = f;
    x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_of = e_of;
    x.e_cnt = e_cnt; x.e_dup = e_dup;
    return x;
  endfunction

  vec_t tbl[20];

  initial begin
    logic [NP*FW-1:0] f;
    tbl[0]  = row(1, 0, 0, 4'h0, '0, 1, 4'h0, '0, 0, 0);
    tbl[1]  = row(0, 0, 0, 4'h1, lf(0, 7'h41), 1, 4'h0, '0, 0, 0);
    tbl[2]  = row(0, 0, 0, 4'h2, lf(1, 7'h02), 1, 4'h0, '0, 0, 0);
    tbl[3]  = row(0, 0, 0, 4'h4, lf(2, 7'h43), 1, 4'h0, '0, 0, 0);
    tbl[4]  = row(0, 0, 0, 4'h8, lf(3, 7'h04), 0, 4'h0, '0, 0, 0);
    tbl[5]  = row(0, 0, 0, 4'h0, '0, 1, 4'hF,
                  lo(0, 11'h401) | lo(1, 11'h002) |
                  lo(2, 11'h403) | lo(3, 11'h004), 1, 0);
    tbl[6]  = row(0, 0, 1, 4'h0, '0, 1, 4'h0, '0, 0, 0);
    tbl[7]  = row(0, 0, 0, 4'h5, lf(0, 7'h15) | lf(2, 7'h7F),
                  1, 4'h0, '0, 0, 0);
    tbl[8]  = row(0, 1, 0, 4'h0, '0, 0, 4'h0, '0, 0, 0);
    tbl[9]  = row(0, 0, 0, 4'h0, '0, 1, 4'h5,
                  lo(0, 11'h015) | lo(2, 11'h43F), 1, 0);
    tbl[10] = row(0, 0, 1, 4'h0, '0, 1, 4'h0, '0, 0, 0);
    tbl[11] = row(0, 1, 0, 4'h0, '0, 1, 4'h0, '0, 0, 0);
    tbl[12] = row(0, 0, 0, 4'h2, lf(1, 7'h11), 1, 4'h0, '0, 0, 0);
    tbl[13] = row(0, 0, 0, 4'h2, lf(1, 7'h22), 1, 4'h0, '0, 0, 1);
    tbl[14] = row(0, 1, 0, 4'h0, '0, 0, 4'h0, '0, 0, 1);
    tbl[15] = row(0, 0, 0, 4'h0, '0, 1, 4'h2, lo(1, 11'h011), 1, 1);
    tbl[16] = row(0, 0, 1, 4'h0, '0, 1, 4'h0, '0, 0, 1);
    tbl[17] = row(0, 1, 0, 4'h8, lf(3, 7'h40), 0, 4'h0, '0, 0, 1);
    tbl[18] = row(0, 0, 0, 4'h0, '0, 1, 4'h8, lo(3, 11'h400), 1, 1);
    tbl[19] = row(0, 0, 1, 4'h0, '0, 1, 4'h0, '0, 0, 1);

    rst = 1'b1; start = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = '0; in_flit = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cmp("rst_in_ready", 64'(in_ready), 64'(1));
    cmp("rst_out_valid", 64'(out_valid), 64'(0));
    cmp("rst_out_flit", 64'(out_flit), 64'(0));
    cmp("rst_count", 64'(count), 64'(0));
    cmp("rst_dup_err", 64'(dup_err), 64'(0));

    for (int i = 0; i < 20; i++) begin
      step(0, tbl[i].st, tbl[i].fl, tbl[i].orr, tbl[i].v, tbl[i].f);
      cmp($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      cmp($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      cmp($sformatf("tbl%0d_out_flit", i), 64'(out_flit), 64'(tbl[i].e_of));
      cmp($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      cmp($sformatf("tbl%0d_dup_err", i), 64'(dup_err), 64'(tbl[i].e_dup));
    end

    // Six groups with no start: FIFO saturates, sixth waits in assembly.
    step(1, 0, 0, 0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      f = '0;
      for (int p = 0; p < NP; p++) f |= lf(p, 7'(k * 16 + p + 1));
      step(0, 0, 0, 0, 4'hF, f);
      step(0, 0, 0, 0, '0, '0);
    end
    cmp("sat_count", 64'(count), 64'(5));
    cmp("sat_in_ready", 64'(in_ready), 64'(0));
    cmp("sat_out_valid", 64'(out_valid), 64'(0));
    step(0, 1, 0, 1, '0, '0);
    cmp("start_count", 64'(count), 64'(5));
    cmp("start_out_valid", 64'(out_valid), 64'(4'hF));
    cmp("start_lane0", 64'(out_flit[OW-1:0]), 64'(11'h001));
    step(0, 0, 0, 1, '0, '0);
    cmp("pushpop_count", 64'(count), 64'(5));
    cmp("pushpop_in_ready", 64'(in_ready), 64'(1));
    cmp("pushpop_lane0", 64'(out_flit[OW-1:0]), 64'(11'h011));
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, '0, '0);
      cmp($sformatf("drain%0d_count", i), 64'(count), 64'(4 - i));
    end

    // Reset in the middle of a drain discards everything.
    step(1, 0, 0, 0, '0, '0);
    step(0, 1, 0, 0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 4'hF, {4{7'(k + 8)}});
      step(0, 0, 0, 0, '0, '0);
    end
    step(0, 0, 0, 0, 4'h1, lf(0, 7'h33));
    step(0, 0, 0, 0, 4'h1, lf(0, 7'h34));
    step(0, 0, 0, 1, '0, '0);
    cmp("mid_count", 64'(count), 64'(3));
    cmp("mid_dup_err", 64'(dup_err), 64'(1));
    step(1, 0, 0, 1, '0, '0);
    cmp("mrst_count", 64'(count), 64'(0));
    cmp("mrst_out_valid", 64'(out_valid), 64'(0));
    cmp("mrst_dup_err", 64'(dup_err), 64'(0));
    cmp("mrst_in_ready", 64'(in_ready), 64'(1));
    step(0, 0, 0, 1, 4'hF, {4{7'h5A}});
    step(0, 0, 0, 1, '0, '0);
    cmp("nostart_count", 64'(count), 64'(1));
    cmp("nostart_out_valid", 64'(out_valid), 64'(0));

    // Random traffic against the group model.
    step(1, 0, 0, 0, '0, '0);
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 249) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) != 0,
           lane_mask_t'($urandom),
           (NP*FW)'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
